data_memory_ctrl: RTL

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte/half/word access, sign/zero extension,
// alignment checking and an optional zero-fill sequence after reset.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_CLEAR | zero-fill one word per cycle; requests are not accepted
//   S_IDLE  | accept one request per cycle; response one cycle later
module data_memory_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqUnsigned,
  input  logic [ADDR_WIDTH-1:0] inAddress,
  input  logic [31:0]           inData,
  output logic                  respValid,
  output logic [31:0]           outData,
  output logic                  respError
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_clr_idx;

  logic [31:0]       r_mem [DEPTH];

  logic              r_resp_valid;
  logic              r_resp_error;
  logic [31:0]       r_resp_data;

  logic              w_accept;
  logic              w_err;
  logic [IDX_W-1:0]  w_word_idx;
  logic [1:0]        w_lane;

  logic [3:0]        w_st_be;
  logic [31:0]       w_st_data;

  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_idx;
  logic [3:0]        w_mem_be;
  logic [31:0]       w_mem_wdata;

  logic [31:0]       w_rd_word;
  logic [7:0]        w_rd_byte;
  logic [15:0]       w_rd_half;
  logic [31:0]       w_load_val;

  assign w_word_idx = inAddress[ADDR_WIDTH-1:2];
  assign w_lane     = inAddress[1:0];

  // Ready is masked by reset directly so it is low for the whole reset
  // window, including when the state register resets straight into S_IDLE.
  assign reqReady = (r_state == S_IDLE) && !reset;
  assign w_accept = reqValid && reqReady;

  assign w_err = (reqSize == 2'b11)
              || ((reqSize == SZ_HALF) && inAddress[0])
              || ((reqSize == SZ_WORD) && (inAddress[1:0] != 2'b00));

  // ------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_idx == LAST_IDX) w_state_next = S_IDLE;
      S_IDLE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Store lane placement
  // ------------------------------------------------------------------
  always_comb begin
    w_st_be   = 4'b0000;
    w_st_data = inData;
    case (reqSize)
      SZ_BYTE: begin
        w_st_be   = 4'b0001 << w_lane;
        w_st_data = {4{inData[7:0]}};
      end
      SZ_HALF: begin
        w_st_be   = inAddress[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{inData[15:0]}};
      end
      SZ_WORD: begin
        w_st_be   = 4'b1111;
        w_st_data = inData;
      end
      default: begin
        w_st_be   = 4'b0000;
        w_st_data = inData;
      end
    endcase
  end

  // Single write port shared between the zero-fill and accepted stores.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_word_idx;
    w_mem_be    = 4'b0000;
    w_mem_wdata = 32'h0;
    if (!reset && (r_state == S_CLEAR)) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_clr_idx;
      w_mem_be    = 4'b1111;
      w_mem_wdata = 32'h0;
    end else if (w_accept && reqWrite && !w_err) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = w_word_idx;
      w_mem_be    = w_st_be;
      w_mem_wdata = w_st_data;
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mem_be[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  // ------------------------------------------------------------------
  // Load extraction: the array is read in the accept cycle, so a store
  // committed on the previous edge is already visible.
  // ------------------------------------------------------------------
  assign w_rd_word = r_mem[w_word_idx];
  assign w_rd_half = inAddress[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_rd_byte = w_rd_word[7:0];
    case (w_lane)
      2'd0:    w_rd_byte = w_rd_word[7:0];
      2'd1:    w_rd_byte = w_rd_word[15:8];
      2'd2:    w_rd_byte = w_rd_word[23:16];
      2'd3:    w_rd_byte = w_rd_word[31:24];
      default: w_rd_byte = w_rd_word[7:0];
    endcase
  end

  always_comb begin
    w_load_val = 32'h0;
    case (reqSize)
      SZ_BYTE: w_load_val = reqUnsigned ? {24'h0, w_rd_byte}
                                        : {{24{w_rd_byte[7]}}, w_rd_byte};
      SZ_HALF: w_load_val = reqUnsigned ? {16'h0, w_rd_half}
                                        : {{16{w_rd_half[15]}}, w_rd_half};
      SZ_WORD: w_load_val = w_rd_word;
      default: w_load_val = 32'h0;
    endcase
  end

  // ------------------------------------------------------------------
  // Response register
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_data  <= 32'h0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_error <= w_accept && w_err;
      r_resp_data  <= (w_accept && !reqWrite && !w_err) ? w_load_val : 32'h0;
    end
  end

  // Masking with reset kills a response whose cycle coincides with reset.
  assign respValid = r_resp_valid && !reset;
  assign respError = r_resp_error && !reset;
  assign outData   = reset ? 32'h0 : r_resp_data;

endmodule
